// File: rtl/hazard_pkg.sv
// Shared types for the load-latency-aware hazard unit.
// Operand-select and FSM state encodings.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LDWAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One operand's forwarding select.
// M-stage result beats W-stage result.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] raE,
  input  logic [REG_AW-1:0] wa3M,
  input  logic [REG_AW-1:0] wa3W,
  input  logic              regWriteM,
  input  logic              regWriteW,
  output fwd_sel_e          fwdSel
);

  always_comb begin
    fwdSel = FWD_RF;
    if (regWriteM && (wa3M == raE))
      fwdSel = FWD_MEM;
    else if (regWriteW && (wa3W == raE))
      fwdSel = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit_ldlat.sv
// Hazard unit with multi-cycle load-use stall and stall watchdog.
// Define HAZARD_UNIT_PERF_EN to add stall/flush counters.
module hazard_unit_ldlat
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int LOAD_LAT  = 1,
  parameter int MAX_STALL = 15,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
`ifdef HAZARD_UNIT_PERF_EN
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt,
`endif
  output logic              StallTimeout
);

  localparam int LW = $clog2(LOAD_LAT + 1);
  localparam int SW = $clog2(MAX_STALL + 1);

  fwd_sel_e  fwdA, fwdB;
  hz_state_e state;
  logic [LW-1:0] latCnt;
  logic [SW-1:0] stallRun;
  logic ldHaz, pcPend, ldStall;
  logic stallFi, flushEi;

  hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdA (
    .raE(RA1E), .wa3M(WA3M), .wa3W(WA3W),
    .regWriteM(RegWriteM), .regWriteW(RegWriteW),
    .fwdSel(fwdA)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdB (
    .raE(RA2E), .wa3M(WA3M), .wa3W(WA3W),
    .regWriteM(RegWriteM), .regWriteW(RegWriteW),
    .fwdSel(fwdB)
  );

  assign ldHaz = MemtoRegE &
                 ((WA3E == RA1D) | (WA3E == RA2D));
  assign pcPend = PCSrcD | PCSrcE | PCSrcM;
  assign ldStall = ((state == IDLE) & ldHaz & ~BranchTakenE)
                 | (state == LDWAIT);

  assign stallFi = ldStall | pcPend;
  assign flushEi = ldStall | BranchTakenE;

  // Outputs are held inactive for the whole reset window.
  assign ForwardAE = rst_n ? fwdA : FWD_RF;
  assign ForwardBE = rst_n ? fwdB : FWD_RF;
  assign StallF = rst_n & stallFi;
  assign StallD = rst_n & ldStall & ~BranchTakenE;
  assign FlushD = rst_n & (pcPend | PCSrcW | BranchTakenE);
  assign FlushE = rst_n & flushEi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      latCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ldHaz && !BranchTakenE && (LOAD_LAT > 1)) begin
            state  <= LDWAIT;
            latCnt <= LW'(LOAD_LAT - 1);
          end
        end
        LDWAIT: begin
          if (BranchTakenE || (latCnt == LW'(1))) begin
            state  <= IDLE;
            latCnt <= '0;
          end else begin
            latCnt <= latCnt - LW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          latCnt <= '0;
        end
      endcase
    end
  end

  // Watchdog: run length saturates, timeout is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallRun     <= '0;
      StallTimeout <= 1'b0;
    end else begin
      if (!stallFi)
        stallRun <= '0;
      else if (stallRun != SW'(MAX_STALL))
        stallRun <= stallRun + SW'(1);
      if (stallFi && (stallRun >= SW'(MAX_STALL - 1)))
        StallTimeout <= 1'b1;
    end
  end

`ifdef HAZARD_UNIT_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (stallFi && (StallCnt != '1))
        StallCnt <= StallCnt + CNT_W'(1);
      if (flushEi && (FlushCnt != '1))
        FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end
`endif

endmodule
